branch_predictor: RTL and testbench

- Parametrised dynamic branch predictor and branch target buffer (BTB) for the IF stage of the 5-stage MIPS pipeline.
- Today the pipeline resolves branches and jumps in ID and always flushes IF/ID. This block predicts direction and target from the fetch PC, so correctly predicted control transfers cost no bubble.
- The ID stage reports each resolved branch/jump back to the block. The block updates its table and reports a mispredict with the corrected PC.

---
 rtl/branch_predictor.sv | 179 +++++++++++++++++
 tb/tb_branch_predictor.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Dynamic branch predictor + BTB for the IF stage.
// Direct-mapped table indexed by pc[IDX_W+1:2]; each entry holds a tag,
// a target and a saturating direction counter. Lookup is combinational,
// updates arrive from ID and are written on the next rising edge.

// One BTB entry: valid/tag/target/counter with async reset and sync clear.
module btb_entry #(
   parameter int ADDR_W = 32,
   parameter int TAG_W  = 26,
   parameter int CTR_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              we,
   input  logic [TAG_W-1:0]  wtag,
   input  logic [ADDR_W-1:0] wtarget,
   input  logic [CTR_W-1:0]  wctr,
   output logic              valid,
   output logic [TAG_W-1:0]  tag,
   output logic [ADDR_W-1:0] target,
   output logic [CTR_W-1:0]  ctr
);

   // Reset value sits one below the taken threshold (weakly not-taken).
   localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(2**(CTR_W-1) - 1);

   // Clear only drops valid and has priority over a same-cycle write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid  <= 1'b0;
         tag    <= '0;
         target <= '0;
         ctr    <= CTR_RST;
      end else if (clr) begin
         valid  <= 1'b0;
      end else if (we) begin
         valid  <= 1'b1;
         tag    <= wtag;
         target <= wtarget;
         ctr    <= wctr;
      end
   end

endmodule

// Top: lookup, update/next-state logic, mispredict and statistics.
module branch_predictor #(
   parameter int ADDR_W  = 32,
   parameter int ENTRIES = 16,
   parameter int CTR_W   = 2,
   parameter int STAT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear_i,
   input  logic [ADDR_W-1:0] pc_i,
   output logic              hit_o,
   output logic              pred_taken_o,
   output logic [ADDR_W-1:0] pred_target_o,
   input  logic              upd_valid_i,
   input  logic [ADDR_W-1:0] upd_pc_i,
   input  logic              upd_is_jump_i,
   input  logic              upd_taken_i,
   input  logic [ADDR_W-1:0] upd_target_i,
   input  logic              upd_pred_taken_i,
   input  logic [ADDR_W-1:0] upd_pred_target_i,
   output logic              mispredict_o,
   output logic [ADDR_W-1:0] redirect_pc_o,
   output logic [STAT_W-1:0] stat_branches_o,
   output logic [STAT_W-1:0] stat_mispred_o
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;
   localparam logic [CTR_W-1:0] CTR_MAX = '1;
   localparam logic [CTR_W-1:0] WEAK_T  = CTR_W'(2**(CTR_W-1));

   logic [ENTRIES-1:0]             ent_valid;
   logic [ENTRIES-1:0][TAG_W-1:0]  ent_tag;
   logic [ENTRIES-1:0][ADDR_W-1:0] ent_target;
   logic [ENTRIES-1:0][CTR_W-1:0]  ent_ctr;
   logic [ENTRIES-1:0]             ent_we;

   // ---------------- lookup (fetch side) ----------------
   logic [IDX_W-1:0] rd_idx;
   logic [TAG_W-1:0] rd_tag;

   assign rd_idx        = pc_i[IDX_W+1:2];
   assign rd_tag        = pc_i[ADDR_W-1:IDX_W+2];
   assign hit_o         = ent_valid[rd_idx] & (ent_tag[rd_idx] == rd_tag);
   assign pred_taken_o  = hit_o & ent_ctr[rd_idx][CTR_W-1];
   assign pred_target_o = pred_taken_o ? ent_target[rd_idx] : pc_i + ADDR_W'(4);

   // ---------------- update (resolve side) ----------------
   logic [IDX_W-1:0]  wr_idx;
   logic [TAG_W-1:0]  wr_tag;
   logic              upd_hit;
   logic [CTR_W-1:0]  cur_ctr;
   logic              wr_en;
   logic [CTR_W-1:0]  new_ctr;
   logic [ADDR_W-1:0] new_target;

   assign wr_idx  = upd_pc_i[IDX_W+1:2];
   assign wr_tag  = upd_pc_i[ADDR_W-1:IDX_W+2];
   assign upd_hit = ent_valid[wr_idx] & (ent_tag[wr_idx] == wr_tag);
   assign cur_ctr = ent_ctr[wr_idx];

   // Next entry contents; a not-taken miss leaves the table alone.
   always_comb begin
      wr_en      = 1'b0;
      new_ctr    = cur_ctr;
      new_target = ent_target[wr_idx];
      if (upd_valid_i) begin
         if (upd_is_jump_i) begin
            wr_en      = 1'b1;
            new_ctr    = CTR_MAX;
            new_target = upd_target_i;
         end else if (upd_hit) begin
            wr_en = 1'b1;
            if (upd_taken_i) begin
               new_ctr    = (cur_ctr == CTR_MAX) ? CTR_MAX : cur_ctr + CTR_W'(1);
               new_target = upd_target_i;
            end else begin
               new_ctr    = (cur_ctr == '0) ? '0 : cur_ctr - CTR_W'(1);
            end
         end else if (upd_taken_i) begin
            wr_en      = 1'b1;
            new_ctr    = WEAK_T;
            new_target = upd_target_i;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < ENTRIES; gi++) begin : g_ent
         assign ent_we[gi] = wr_en & (wr_idx == IDX_W'(gi));
         btb_entry #(
            .ADDR_W (ADDR_W),
            .TAG_W  (TAG_W),
            .CTR_W  (CTR_W)
         ) u_ent (
            .clk     (clk_i),
            .rst     (rst_i),
            .clr     (clear_i),
            .we      (ent_we[gi]),
            .wtag    (wr_tag),
            .wtarget (new_target),
            .wctr    (new_ctr),
            .valid   (ent_valid[gi]),
            .tag     (ent_tag[gi]),
            .target  (ent_target[gi]),
            .ctr     (ent_ctr[gi])
         );
      end
   endgenerate

   // ---------------- mispredict / redirect ----------------
   assign mispredict_o  = upd_valid_i &
                          ((upd_taken_i != upd_pred_taken_i) |
                           (upd_taken_i & upd_pred_taken_i &
                            (upd_target_i != upd_pred_target_i)));
   assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + ADDR_W'(4);

   // Saturating statistics; deliberately untouched by clear_i.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stat_branches_o <= '0;
         stat_mispred_o  <= '0;
      end else if (upd_valid_i) begin
         if (stat_branches_o != '1)
            stat_branches_o <= stat_branches_o + STAT_W'(1);
         if (mispredict_o && (stat_mispred_o != '1))
            stat_mispred_o <= stat_mispred_o + STAT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (default parameters).
// Each row: inputs for one cycle plus the outputs expected before the edge.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic [31:0] pc = '0;
   logic        hit, pt;
   logic [31:0] ptgt;
   logic        uv = 1'b0, uj = 1'b0, ut = 1'b0, upt = 1'b0;
   logic [31:0] upc = '0, utg = '0, uptg = '0;
   logic        misp;
   logic [31:0] rdir;
   logic [15:0] st_br, st_mp;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   branch_predictor dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .clear_i           (clear),
      .pc_i              (pc),
      .hit_o             (hit),
      .pred_taken_o      (pt),
      .pred_target_o     (ptgt),
      .upd_valid_i       (uv),
      .upd_pc_i          (upc),
      .upd_is_jump_i     (uj),
      .upd_taken_i       (ut),
      .upd_target_i      (utg),
      .upd_pred_taken_i  (upt),
      .upd_pred_target_i (uptg),
      .mispredict_o      (misp),
      .redirect_pc_o     (rdir),
      .stat_branches_o   (st_br),
      .stat_mispred_o    (st_mp)
   );

   typedef struct {
      logic        clr;
      logic [31:0] pc;
      logic        uv;
      logic [31:0] upc;
      logic        uj, ut;
      logic [31:0] utg;
      logic        upt;
      logic [31:0] uptg;
      logic        e_hit, e_pt;
      logic [31:0] e_tgt;
      logic        e_mp;
      logic [31:0] e_rd;
      int          e_br, e_ms;
   } vec_t;

   localparam int NV = 28;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic c, input logic [31:0] p,
                               input logic v, input logic [31:0] up,
                               input logic j, input logic t, input logic [31:0] tg,
                               input logic pt_, input logic [31:0] ptg,
                               input logic eh, input logic ep, input logic [31:0] et,
                               input logic em, input logic [31:0] er,
                               input int eb, input int es);
      vec_t r;
      r.clr = c;  r.pc = p;   r.uv = v;   r.upc = up;
      r.uj = j;   r.ut = t;   r.utg = tg; r.upt = pt_; r.uptg = ptg;
      r.e_hit = eh; r.e_pt = ep; r.e_tgt = et; r.e_mp = em; r.e_rd = er;
      r.e_br = eb; r.e_ms = es;
      return r;
   endfunction

   task automatic chk(input string name, input int step,
                      input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s step %0d actual %h expected %h", name, step, act, exp);
      end
   endtask

   task automatic idle_upd();
      uv = 1'b0; upc = '0; uj = 1'b0; ut = 1'b0; utg = '0; upt = 1'b0; uptg = '0;
   endtask

   initial begin
      //             clr pc            uv upc           uj ut utg          upt uptg          hit pt tgt          mp redirect     br ms
      tbl[0]  = mk(0, 32'h40,       0, 32'h0,        0, 0, 32'h0,       0, 32'h0,       0, 0, 32'h44,       0, 32'h4,       0, 0);
      tbl[1]  = mk(0, 32'h40,       1, 32'h40,       0, 1, 32'h80,      0, 32'h0,       0, 0, 32'h44,       1, 32'h80,      0, 0);
      tbl[2]  = mk(0, 32'h40,       0, 32'h0,        0, 0, 32'h0,       0, 32'h0,       1, 1, 32'h80,       0, 32'h4,       1, 1);
      tbl[3]  = mk(0, 32'h40,       1, 32'h40,       0, 1, 32'h80,      1, 32'h80,      1, 1, 32'h80,       0, 32'h80,      1, 1);
      tbl[4]  = mk(0, 32'h40,       1, 32'h40,       0, 1, 32'h80,      1, 32'h80,      1, 1, 32'h80,       0, 32'h80,      2, 1);
      tbl[5]  = mk(0, 32'h40,       1, 32'h40,       0, 1, 32'h80,      1, 32'h80,      1, 1, 32'h80,       0, 32'h80,      3, 1);
      tbl[6]  = mk(0, 32'h40,       1, 32'h40,       0, 0, 32'h80,      1, 32'h80,      1, 1, 32'h80,       1, 32'h44,      4, 1);
      tbl[7]  = mk(0, 32'h40,       1, 32'h40,       0, 0, 32'h0,       1, 32'h80,      1, 1, 32'h80,       1, 32'h44,      5, 2);
      tbl[8]  = mk(0, 32'h40,       1, 32'h40,       0, 0, 32'h0,       0, 32'h44,      1, 0, 32'h44,       0, 32'h44,      6, 3);
      tbl[9]  = mk(0, 32'h40,       1, 32'h40,       0, 0, 32'h0,       0, 32'h44,      1, 0, 32'h44,       0, 32'h44,      7, 3);
      tbl[10] = mk(0, 32'h40,       1, 32'h40,       0, 1, 32'h80,      0, 32'h44,      1, 0, 32'h44,       1, 32'h80,      8, 3);
      tbl[11] = mk(0, 32'h40,       0, 32'h0,        0, 0, 32'h0,       0, 32'h0,       1, 0, 32'h44,       0, 32'h4,       9, 4);
      tbl[12] = mk(0, 32'h80,       1, 32'h80,       0, 1, 32'h200,     0, 32'h84,      0, 0, 32'h84,       1, 32'h200,     9, 4);
      tbl[13] = mk(0, 32'h40,       0, 32'h0,        0, 0, 32'h0,       0, 32'h0,       0, 0, 32'h44,       0, 32'h4,       10, 5);
      tbl[14] = mk(0, 32'h80,       0, 32'h0,        0, 0, 32'h0,       0, 32'h0,       1, 1, 32'h200,      0, 32'h4,       10, 5);
      tbl[15] = mk(0, 32'h84,       1, 32'h80,       0, 1, 32'h240,     1, 32'h200,     0, 0, 32'h88,       1, 32'h240,     10, 5);
      tbl[16] = mk(0, 32'h80,       0, 32'h0,        0, 0, 32'h0,       0, 32'h0,       1, 1, 32'h240,      0, 32'h4,       11, 6);
      tbl[17] = mk(0, 32'h10,       1, 32'h10,       1, 1, 32'h300,     1, 32'h2FC,     0, 0, 32'h14,       1, 32'h300,     11, 6);
      tbl[18] = mk(0, 32'h10,       0, 32'h0,        0, 0, 32'h0,       0, 32'h0,       1, 1, 32'h300,      0, 32'h4,       12, 7);
      tbl[19] = mk(0, 32'h10,       1, 32'h10,       0, 0, 32'h0,       1, 32'h300,     1, 1, 32'h300,      1, 32'h14,      12, 7);
      tbl[20] = mk(0, 32'h10,       0, 32'h0,        0, 0, 32'h0,       0, 32'h0,       1, 1, 32'h300,      0, 32'h4,       13, 8);
      tbl[21] = mk(0, 32'h24,       1, 32'h24,       0, 0, 32'h0,       0, 32'h28,      0, 0, 32'h28,       0, 32'h28,      13, 8);
      tbl[22] = mk(0, 32'h24,       0, 32'h0,        0, 0, 32'h0,       0, 32'h0,       0, 0, 32'h28,       0, 32'h4,       14, 8);
      tbl[23] = mk(0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 0, 32'h0,       0, 32'h0,       0, 0, 32'h0,        0, 32'h0,       14, 8);
      tbl[24] = mk(1, 32'h80,       1, 32'h44,       0, 1, 32'h500,     0, 32'h48,      1, 1, 32'h240,      1, 32'h500,     15, 8);
      tbl[25] = mk(0, 32'h80,       0, 32'h0,        0, 0, 32'h0,       0, 32'h0,       0, 0, 32'h84,       0, 32'h4,       16, 9);
      tbl[26] = mk(0, 32'h44,       0, 32'h0,        0, 0, 32'h0,       0, 32'h0,       0, 0, 32'h48,       0, 32'h4,       16, 9);
      tbl[27] = mk(0, 32'h10,       0, 32'h0,        0, 0, 32'h0,       0, 32'h0,       0, 0, 32'h14,       0, 32'h4,       16, 9);

      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         clear = tbl[i].clr; pc = tbl[i].pc;
         uv = tbl[i].uv; upc = tbl[i].upc; uj = tbl[i].uj; ut = tbl[i].ut;
         utg = tbl[i].utg; upt = tbl[i].upt; uptg = tbl[i].uptg;
         #1;
         chk("hit",         i, 32'(hit),   32'(tbl[i].e_hit));
         chk("pred_taken",  i, 32'(pt),    32'(tbl[i].e_pt));
         chk("pred_target", i, ptgt,       tbl[i].e_tgt);
         chk("mispredict",  i, 32'(misp),  32'(tbl[i].e_mp));
         chk("redirect",    i, rdir,       tbl[i].e_rd);
         chk("stat_br",     i, 32'(st_br), 32'(tbl[i].e_br));
         chk("stat_mp",     i, 32'(st_mp), 32'(tbl[i].e_ms));
      end

      // Re-allocate 0x10 so the asynchronous reset has something to wipe.
      @(negedge clk);
      clear = 1'b0; pc = 32'h10;
      uv = 1'b1; upc = 32'h10; uj = 1'b0; ut = 1'b1; utg = 32'h300; upt = 1'b0; uptg = '0;
      #1;
      chk("realloc_pre_hit", 100, 32'(hit), 32'h0);
      @(negedge clk);
      idle_upd();
      #1;
      chk("realloc_hit",    101, 32'(hit),   32'h1);
      chk("realloc_target", 101, ptgt,       32'h300);
      chk("realloc_br",     101, 32'(st_br), 32'd17);
      chk("realloc_mp",     101, 32'(st_mp), 32'd10);

      // Asynchronous reset between edges: outputs clear without a clock.
      #1 rst = 1'b1;
      #1;
      chk("areset_hit",    102, 32'(hit),   32'h0);
      chk("areset_pt",     102, 32'(pt),    32'h0);
      chk("areset_target", 102, ptgt,       32'h14);
      chk("areset_br",     102, 32'(st_br), 32'h0);
      chk("areset_mp",     102, 32'(st_mp), 32'h0);

      // Update presented while reset is held is discarded.
      uv = 1'b1; upc = 32'h10; ut = 1'b1; utg = 32'h300; upt = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle_upd();
      #1;
      chk("rst_upd_hit", 103, 32'(hit),   32'h0);
      chk("rst_upd_tgt", 103, ptgt,       32'h14);
      chk("rst_upd_br",  103, 32'(st_br), 32'h0);
      chk("rst_upd_mp",  103, 32'(st_mp), 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
